// File: rtl/fan_pkg.sv
// Shared types and helpers for the fan PWM ramp controller.
package fan_pkg;

  typedef logic [3:0] fan_level_t;

  typedef enum logic [1:0] {
    IDLE,
    KICK,
    RUN
  } fan_state_e;

  localparam int FanMaxLevel = 15;

  // One ramp step: move a level one unit toward a target, or hold if equal.
  function automatic fan_level_t fan_step_toward(input fan_level_t level,
                                                 input fan_level_t target);
    fan_level_t result;
    result = level;
    if (target > level) begin
      result = level + fan_level_t'(1);
    end else if (target < level) begin
      result = level - fan_level_t'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/fan_sw_debounce.sv
// Two-flop synchroniser and debounce filter for the 4-bit fan switch setting.
// The target only follows a value that has sat unchanged on the synchronised
// bus long enough; any change restarts the wait.
module fan_sw_debounce
  import fan_pkg::*;
#(
  parameter int Cycles = 50_000
) (
  input  logic       soc_clk,
  input  logic       rst_n,
  input  fan_level_t setting_i,
  output fan_level_t target_o
);

  localparam int CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

  fan_level_t      r_sync1;
  fan_level_t      r_sync2;
  fan_level_t      r_last;
  fan_level_t      r_target;
  logic [CntW-1:0] r_cnt;

  // Bring the asynchronous switch bus into the soc_clk domain.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= setting_i;
      r_sync2 <= r_sync1;
    end
  end

  // Restart the stability count on any change; adopt the value once it has held.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= '0;
      r_cnt    <= '0;
      r_target <= '0;
    end else if (r_sync2 != r_last) begin
      r_last <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt == CntLast) begin
      r_target <= r_last;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign target_o = r_target;

endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan speed controller: debounced switch target, kick-start after a stop,
// timed one-level ramping toward the target, and a wrap-aligned PWM output.
module fan_pwm_ramp
  import fan_pkg::*;
#(
  parameter int ClkFreqHz      = 50_000_000,
  parameter int PwmFreqHz      = 25_000,
  parameter int DebounceCycles = 50_000,
  parameter int RampStepCycles = 500_000,
  parameter int KickCycles     = 25_000_000
) (
  input  logic       soc_clk,
  input  logic       rst_n,
  input  logic [3:0] pwm_setting_i,
  input  logic       force_full_i,
  output logic       fan_pwm_o,
  output logic [3:0] level_o,
  output logic [3:0] target_o,
  output logic       kick_o
);

  localparam int PeriodCycles = ClkFreqHz / PwmFreqHz;
  localparam int SlotCycles   = PeriodCycles / FanMaxLevel;
  localparam int PeriodW      = (PeriodCycles > 1) ? $clog2(PeriodCycles) : 1;
  localparam int KickW        = (KickCycles > 1) ? $clog2(KickCycles) : 1;
  localparam int StepW        = (RampStepCycles > 1) ? $clog2(RampStepCycles) : 1;

  localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(PeriodCycles - 1);
  localparam logic [PeriodW-1:0] SlotLen    = PeriodW'(SlotCycles);
  localparam logic [KickW-1:0]   KickLast   = KickW'(KickCycles - 1);
  localparam logic [StepW-1:0]   StepLast   = StepW'(RampStepCycles - 1);
  localparam fan_level_t         MaxLevel   = fan_level_t'(FanMaxLevel);

  if (PeriodCycles < FanMaxLevel) begin : g_period_check
    $error("fan_pwm_ramp: ClkFreqHz/PwmFreqHz must be at least 15");
  end

  fan_level_t          w_target;
  fan_state_e          r_state;
  fan_state_e          w_state_nxt;
  fan_level_t          r_level;
  fan_level_t          w_level_nxt;
  logic [KickW-1:0]    r_kick_cnt;
  logic [KickW-1:0]    w_kick_cnt_nxt;
  logic [StepW-1:0]    r_step_cnt;
  logic [StepW-1:0]    w_step_cnt_nxt;
  logic [PeriodW-1:0]  r_period_cnt;
  logic [PeriodW-1:0]  w_threshold;
  fan_level_t          r_cmp;
  logic                w_pwm_nxt;
  logic                r_pwm;

  fan_sw_debounce #(
    .Cycles(DebounceCycles)
  ) u_debounce (
    .soc_clk  (soc_clk),
    .rst_n    (rst_n),
    .setting_i(pwm_setting_i),
    .target_o (w_target)
  );

  // Controller state, applied level and the kick/ramp timers.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_level    <= '0;
      r_kick_cnt <= '0;
      r_step_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_kick_cnt <= w_kick_cnt_nxt;
      r_step_cnt <= w_step_cnt_nxt;
    end
  end

  // Next-state logic: kick after a stop, then ramp one level per step period.
  always_comb begin
    w_state_nxt    = r_state;
    w_level_nxt    = r_level;
    w_kick_cnt_nxt = '0;
    w_step_cnt_nxt = '0;
    case (r_state)
      IDLE: begin
        w_level_nxt = '0;
        if (w_target != '0) begin
          w_state_nxt = KICK;
        end
      end
      KICK: begin
        if (w_target == '0) begin
          w_state_nxt = IDLE;
          w_level_nxt = '0;
        end else if (r_kick_cnt == KickLast) begin
          w_state_nxt = RUN;
          w_level_nxt = w_target;
        end else begin
          w_kick_cnt_nxt = r_kick_cnt + 1'b1;
        end
      end
      RUN: begin
        if (r_level != w_target) begin
          if (r_step_cnt == StepLast) begin
            w_level_nxt = fan_step_toward(r_level, w_target);
            if (w_level_nxt == '0) begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_step_cnt_nxt = r_step_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_level_nxt = '0;
      end
    endcase
  end

  // Free-running PWM period counter; the duty compare only reloads at the wrap.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
      r_cmp        <= '0;
    end else if (r_period_cnt == PeriodLast) begin
      r_period_cnt <= '0;
      r_cmp        <= r_level;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  // PWM compare: constant high while kicking or forced, low when idle.
  always_comb begin
    w_threshold = PeriodW'(r_cmp) * SlotLen;
    w_pwm_nxt   = 1'b0;
    case (r_state)
      KICK:    w_pwm_nxt = 1'b1;
      RUN:     w_pwm_nxt = (r_cmp == MaxLevel) || (r_period_cnt < w_threshold);
      default: w_pwm_nxt = 1'b0;
    endcase
    if (force_full_i) begin
      w_pwm_nxt = 1'b1;
    end
  end

  // Register the PWM pin so it never glitches.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_pwm_nxt;
    end
  end

  assign fan_pwm_o = r_pwm;
  assign level_o   = r_level;
  assign target_o  = w_target;
  assign kick_o    = (r_state == KICK);

endmodule

// File: tb/tb_fan_pwm_ramp.sv
// Bench for fan_pwm_ramp: directed steps plus random switch/force activity,
// compared every cycle against a behavioural model of the controller.
module tb_fan_pwm_ramp;

  localparam int ClkFreqHz      = 1500;
  localparam int PwmFreqHz      = 100;
  localparam int DebounceCycles = 4;
  localparam int RampStepCycles = 10;
  localparam int KickCycles     = 20;
  localparam int Period         = ClkFreqHz / PwmFreqHz;
  localparam int Slot           = Period / 15;

  localparam int ModeIdle = 0;
  localparam int ModeKick = 1;
  localparam int ModeRun  = 2;

  logic       soc_clk;
  logic       rst_n;
  logic [3:0] pwm_setting_i;
  logic       force_full_i;
  logic       fan_pwm_o;
  logic [3:0] level_o;
  logic [3:0] target_o;
  logic       kick_o;

  int testsRun    = 0;
  int testsFailed = 0;

  // Behavioural model state
  int   hist[$];
  int   mTarget;
  int   mLevel;
  int   mMode;
  int   mCycle;
  int   mKickEnd;
  int   mUnequal;
  int   mPos;
  int   mDuty;
  logic mPwm;
  logic pwmNext;
  int   tgtOld;
  bit   stable;

  fan_pwm_ramp #(
    .ClkFreqHz     (ClkFreqHz),
    .PwmFreqHz     (PwmFreqHz),
    .DebounceCycles(DebounceCycles),
    .RampStepCycles(RampStepCycles),
    .KickCycles    (KickCycles)
  ) dut (
    .soc_clk      (soc_clk),
    .rst_n        (rst_n),
    .pwm_setting_i(pwm_setting_i),
    .force_full_i (force_full_i),
    .fan_pwm_o    (fan_pwm_o),
    .level_o      (level_o),
    .target_o     (target_o),
    .kick_o       (kick_o)
  );

  initial begin
    soc_clk = 1'b0;
    forever #5 soc_clk = ~soc_clk;
  end

  task automatic modelReset();
    hist.delete();
    repeat (DebounceCycles + 3) hist.push_back(0);
    mTarget  = 0;
    mLevel   = 0;
    mMode    = ModeIdle;
    mCycle   = 0;
    mKickEnd = 0;
    mUnequal = 0;
    mPos     = 0;
    mDuty    = 0;
    mPwm     = 1'b0;
  endtask

  // Reference model: every rule evaluated from the values held before the edge.
  always @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      modelReset();
    end else begin
      mCycle = mCycle + 1;
      tgtOld = mTarget;

      pwmNext = force_full_i || (mMode == ModeKick) ||
                ((mMode == ModeRun) && ((mDuty == 15) || (mPos < mDuty * Slot)));

      if (mPos == Period - 1) begin
        mPos  = 0;
        mDuty = mLevel;
      end else begin
        mPos = mPos + 1;
      end

      if (mMode == ModeIdle) begin
        mLevel = 0;
        if (tgtOld != 0) begin
          mMode    = ModeKick;
          mKickEnd = mCycle + KickCycles;
        end
      end else if (mMode == ModeKick) begin
        if (tgtOld == 0) begin
          mMode  = ModeIdle;
          mLevel = 0;
        end else if (mCycle == mKickEnd) begin
          mMode    = ModeRun;
          mLevel   = tgtOld;
          mUnequal = 0;
        end
      end else begin
        if (mLevel != tgtOld) begin
          mUnequal = mUnequal + 1;
          if (mUnequal == RampStepCycles) begin
            mUnequal = 0;
            mLevel   = (tgtOld > mLevel) ? mLevel + 1 : mLevel - 1;
            if (mLevel == 0) mMode = ModeIdle;
          end
        end else begin
          mUnequal = 0;
        end
      end

      hist.push_back(int'(pwm_setting_i));
      void'(hist.pop_front());
      stable = 1'b1;
      for (int i = 1; i <= DebounceCycles; i++) begin
        if (hist[i] != hist[0]) stable = 1'b0;
      end
      if (stable) mTarget = hist[0];

      mPwm = pwmNext;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("pwm", 32'(fan_pwm_o), 32'(mPwm));
    checkVal("level", 32'(level_o), 32'(mLevel));
    checkVal("target", 32'(target_o), 32'(mTarget));
    checkVal("kick", 32'(kick_o), 32'(mMode == ModeKick));
  endtask

  task automatic applyStimulus(input logic [3:0] sw, input logic frc);
    pwm_setting_i = sw;
    force_full_i  = frc;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge soc_clk);
      checkOutput();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'd0, 1'b0);
    repeat (3) @(negedge soc_clk);
    rst_n = 1'b1;

    // Idle with switches at zero
    runCycles(200);
    checkVal("idle_pwm", 32'(fan_pwm_o), 32'd0);
    checkVal("idle_level", 32'(level_o), 32'd0);

    // 0 -> 5: debounce latency, kick window, then run at level 5
    applyStimulus(4'd5, 1'b0);
    runCycles(6);
    checkVal("deb_before", 32'(target_o), 32'd0);
    runCycles(1);
    checkVal("deb_after", 32'(target_o), 32'd5);
    checkVal("kick_not_yet", 32'(kick_o), 32'd0);
    runCycles(1);
    checkVal("kick_rise", 32'(kick_o), 32'd1);
    runCycles(19);
    checkVal("kick_hold", 32'(kick_o), 32'd1);
    checkVal("kick_pwm", 32'(fan_pwm_o), 32'd1);
    runCycles(1);
    checkVal("kick_end", 32'(kick_o), 32'd0);
    checkVal("run_level5", 32'(level_o), 32'd5);
    runCycles(60);

    // 5 -> 8: one level per ramp step
    applyStimulus(4'd8, 1'b0);
    runCycles(17);
    checkVal("ramp_6", 32'(level_o), 32'd6);
    runCycles(10);
    checkVal("ramp_7", 32'(level_o), 32'd7);
    runCycles(10);
    checkVal("ramp_8", 32'(level_o), 32'd8);
    runCycles(30);

    // Short glitch on the switches never reaches the target
    applyStimulus(4'd9, 1'b0);
    runCycles(3);
    applyStimulus(4'd8, 1'b0);
    for (int i = 0; i < 12; i++) begin
      runCycles(1);
      checkVal("glitch_target", 32'(target_o), 32'd8);
    end

    // 8 -> 0: ramp down over eight steps, then idle and low
    applyStimulus(4'd0, 1'b0);
    runCycles(86);
    checkVal("down_1", 32'(level_o), 32'd1);
    runCycles(1);
    checkVal("down_0", 32'(level_o), 32'd0);
    runCycles(1);
    checkVal("down_pwm", 32'(fan_pwm_o), 32'd0);
    runCycles(20);

    // Target drops to zero during the kick
    applyStimulus(4'd3, 1'b0);
    runCycles(8);
    checkVal("abort_kick_on", 32'(kick_o), 32'd1);
    runCycles(5);
    applyStimulus(4'd0, 1'b0);
    runCycles(8);
    checkVal("abort_kick_off", 32'(kick_o), 32'd0);
    checkVal("abort_level", 32'(level_o), 32'd0);
    runCycles(1);
    checkVal("abort_pwm", 32'(fan_pwm_o), 32'd0);
    runCycles(10);

    // Force-full pulse at level 3
    applyStimulus(4'd3, 1'b0);
    runCycles(28);
    checkVal("force_pre_level", 32'(level_o), 32'd3);
    runCycles(30);
    applyStimulus(4'd3, 1'b1);
    runCycles(1);
    for (int i = 0; i < 29; i++) begin
      runCycles(1);
      checkVal("force_pwm", 32'(fan_pwm_o), 32'd1);
      checkVal("force_level", 32'(level_o), 32'd3);
    end
    applyStimulus(4'd3, 1'b0);
    runCycles(45);

    // Random switch settings and force pulses
    for (int s = 0; s < 25; s++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
      runCycles(int'($urandom_range(1, 60)));
    end

    // Asynchronous reset in the middle of a ramp
    applyStimulus(4'd2, 1'b0);
    runCycles(200);
    applyStimulus(4'd15, 1'b0);
    runCycles(40);
    checkVal("midramp_level", 32'(level_o), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    checkVal("arst_pwm", 32'(fan_pwm_o), 32'd0);
    checkVal("arst_level", 32'(level_o), 32'd0);
    checkVal("arst_target", 32'(target_o), 32'd0);
    checkVal("arst_kick", 32'(kick_o), 32'd0);
    runCycles(3);
    rst_n = 1'b1;
    runCycles(60);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
